// File: rtl/mem_bist_pkg.sv
// Shared types and defaults for the memory BIST sequencer.
// MEM_BIST_INV_PASS_EN (see mem_bist_ctrl) adds an inverted-pattern pass.
package mem_bist_pkg;

  localparam int DEPTH_DEF  = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int ERR_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_READ,
    ST_DONE
  } state_e;

  // Bit i of the replicated address byte {N{a[7:0]}}.
  function automatic logic lane_bit(input logic [7:0] a8, input int i);
    return a8[3'(i % 8)];
  endfunction

endpackage

// File: rtl/mem_bist_if.sv
// Memory-side port of the BIST sequencer: controller drives enables, address
// and write data; the memory returns combinational read data.
interface mem_bist_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              Mem_Read;
  logic              Mem_Write;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] M_W_Data;
  logic [DATA_W-1:0] M_R_Data;

  modport master (
    output Mem_Read, Mem_Write, Mem_Addr, M_W_Data,
    input  M_R_Data
  );

  modport slave (
    input  Mem_Read, Mem_Write, Mem_Addr, M_W_Data,
    output M_R_Data
  );
endinterface

// File: rtl/mem_bist_pattern.sv
// Address-dependent test pattern: seed ^ {N{addr[7:0]}}, optionally inverted.
module mem_bist_pattern
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] seed,
  input  logic              invert,
  output logic [DATA_W-1:0] pat
);

  logic [7:0] lane;

  always_comb begin
    lane = 8'(addr);
    pat  = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pat[i] = seed[i] ^ lane_bit(lane, i) ^ invert;
    end
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST sequencer: write pattern, one gap cycle, read back and compare.
// Define MEM_BIST_INV_PASS_EN to follow with a second pass using ~pattern.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  mem_bist_if.master        mem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  seed_q, seed_d;
  logic               inv_q, inv_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [ADDR_W-1:0]  ferr_q, ferr_d;
  logic               pass_q, pass_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  maddr_q, maddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  pat_nxt, pat_cur;
  logic               mismatch;

  // Write data is registered, so it is generated from next-cycle address/seed.
  mem_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pat_nxt (
    .addr   (addr_d),
    .seed   (seed_d),
    .invert (inv_d),
    .pat    (pat_nxt)
  );

  mem_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pat_cur (
    .addr   (addr_q),
    .seed   (seed_q),
    .invert (inv_q),
    .pat    (pat_cur)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    seed_d   = seed_q;
    inv_d    = inv_q;
    err_d    = err_q;
    ferr_d   = ferr_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    busy_d   = 1'b1;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    mismatch = (state_q == ST_READ) && (mem.M_R_Data != pat_cur);

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_WRITE;
          seed_d  = seed;
          inv_d   = 1'b0;
          err_d   = '0;
          ferr_d  = '0;
          pass_d  = 1'b0;
          addr_d  = '0;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = ST_GAP;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          wr_d   = 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_READ;
        addr_d  = '0;
        rd_d    = 1'b1;
      end
      ST_READ: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (err_q == '0)      ferr_d = addr_q;
        end
        if (addr_q != LAST_ADDR) begin
          addr_d = addr_q + 1'b1;
          rd_d   = 1'b1;
        end else begin
          addr_d = '0;
`ifdef MEM_BIST_INV_PASS_EN
          if (!inv_q) begin
            state_d = ST_WRITE;
            inv_d   = 1'b1;
            wr_d    = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Address and data are forced to zero whenever no access is issued.
  always_comb begin
    maddr_d = (rd_d || wr_d) ? addr_d : '0;
    wdata_d = wr_d ? pat_nxt : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      inv_q   <= 1'b0;
      err_q   <= '0;
      ferr_q  <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    seed_q <= seed_d;
  end

  assign mem.Mem_Read    = rd_q;
  assign mem.Mem_Write   = wr_q;
  assign mem.Mem_Addr    = maddr_q;
  assign mem.M_W_Data    = wdata_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign first_err_addr  = ferr_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl with a 32-word memory model and fault modes.
module tb_mem_bist_ctrl;

`ifdef MEM_BIST_INV_PASS_EN
  localparam int NP  = 2;
  localparam int LAT = 130;
`else
  localparam int NP  = 1;
  localparam int LAT = 65;
`endif

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int         cyc;
    logic       pass;
    logic [7:0] err;
    logic [7:0] ferr;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed_in = '0;
  logic        busy, done, pass;
  logic [7:0]  err_cnt, first_err_addr;

  mem_bist_if #(.ADDR_W(8), .DATA_W(32)) mif ();

  mem_bist_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .seed           (seed_in),
    .mem            (mif.master),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int d0 = 0;
  int fault = 0;
  bit both_seen = 0;
  bit idle_bad = 0;
  wr_t  wq[$];
  res_t rq[$];

  logic [31:0] mem_arr [32];
  logic [31:0] rdata;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mif.Mem_Write) mem_arr[mif.Mem_Addr[4:0]] <= mif.M_W_Data;
  end

  // Fault 1: bit 0 stuck-at-0 at address 5. Fault 2: bit 3 flipped everywhere.
  always_comb begin
    rdata = mem_arr[mif.Mem_Addr[4:0]];
    if (fault == 1 && mif.Mem_Addr == 8'd5) rdata[0] = 1'b0;
    if (fault == 2) rdata = rdata ^ 32'h0000_0008;
  end
  assign mif.M_R_Data = rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mif.Mem_Read && mif.Mem_Write) both_seen = 1;
    if (!mif.Mem_Write && mif.M_W_Data != 0) idle_bad = 1;
    if (!mif.Mem_Write && !mif.Mem_Read && mif.Mem_Addr != 0) idle_bad = 1;
    if (mif.Mem_Write) begin
      if (wq.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", mif.Mem_Addr, e.addr);
        chk("wr_data", mif.M_W_Data, e.data);
      end
    end
    if (done) begin
      done_cnt++;
      if (rq.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        res_t r;
        r = rq.pop_front();
        chk("done_cycle", cyc, r.cyc);
        chk("pass", pass, r.pass);
        chk("err_cnt", err_cnt, r.err);
        chk("first_err_addr", first_err_addr, r.ferr);
      end
    end
  end

  task automatic kick(input logic [31:0] s, input logic ep, input logic [7:0] ee,
                      input logic [7:0] ef);
    res_t r;
    @(negedge clk);
    seed_in = s;
    start   = 1'b1;
    d0      = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int p = 0; p < NP; p++) begin
      for (int a = 0; a < 32; a++) begin
        wr_t w;
        logic [7:0] a8;
        a8     = 8'(a);
        w.addr = a8;
        w.data = s ^ {a8, a8, a8, a8};
        if (p == 1) w.data = ~w.data;
        wq.push_back(w);
      end
    end
    r.cyc  = cyc + LAT;
    r.pass = ep;
    r.err  = ee;
    r.ferr = ef;
    rq.push_back(r);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done_cnt == d0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [31:0] s, input int f, input logic ep,
                     input logic [7:0] ee, input logic [7:0] ef);
    fault = f;
    kick(s, ep, ee, ef);
    wait_done(300);
    repeat (3) @(negedge clk);
    chk("hold_pass", pass, ep);
    chk("hold_err", err_cnt, ee);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem_arr[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", mif.Mem_Read, 0);
    chk("rst_wr", mif.Mem_Write, 0);
    chk("rst_addr", mif.Mem_Addr, 0);
    chk("rst_wdata", mif.M_W_Data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_ferr", first_err_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(32'h0000_0000, 0, 1'b1, 8'd0, 8'd0);
    run(32'hFFFF_FFFF, 0, 1'b1, 8'd0, 8'd0);
    run(32'h0000_0000, 1, 1'b0, 8'd1, 8'd5);

    // Start pulse during READ must be ignored.
    fault = 0;
    kick(32'h1234_5678, 1'b1, 8'd0, 8'd0);
    repeat (40) @(negedge clk);
    chk("mid_busy", busy, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(300);
    repeat (80) @(negedge clk);
    chk("one_done", done_cnt, d0 + 1);

    // Reset in the middle of WRITE.
    kick(32'hA5A5_5A5A, 1'b1, 8'd0, 8'd0);
    repeat (10) @(negedge clk);
    chk("pre_rst_wr", mif.Mem_Write, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_wr", mif.Mem_Write, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_err", err_cnt, 0);
    chk("rst_mid_done", done, 0);
    rst = 1'b0;
    wq.delete();
    rq.delete();
    repeat (150) @(negedge clk);
    chk("no_done_after_rst", done_cnt, d0);

    run(32'h0F0F_0000, 2, 1'b0, 8'(32 * NP), 8'd0);

    chk("never_both_enables", both_seen, 0);
    chk("idle_outputs_zero", idle_bad, 0);
    chk("wq_drained", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
